if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_if.sv | 18 +
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//   req   : fetch request (fetch stage -> memory)
//   addr  : fetch address, equal to the fetch stage's PC
//   ack   : rdata is valid for the address presented this cycle
//   rdata : fetched 32-bit instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over the imem
// request/acknowledge bus and drives the IF/ID pipeline register.
// Honours freeze (stall from hazard detection) and branch redirects from ID.
//
// Optional feature macro: IF_SKID_BUF_EN
//   defined   : a one-entry skid buffer catches a word acknowledged while
//               frozen; the stage parks in BUFFERED until the freeze lifts.
//   undefined : no skid storage; requests are withheld while frozen, and an
//               ack during a freeze is ignored so the word is re-fetched.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : IF/ID must hold
//   br_taken/br_addr: redirect PC to br_addr, flush IF/ID
//   imem            : instruction memory bus (master side)
//   if_id_valid     : IF/ID holds a real instruction (0 = bubble)
//   if_id_pc        : PC+4 of the IF/ID instruction
//   if_id_instr     : IF/ID instruction word
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_addr,
    if_fetch_stage_if.master    imem,
    output logic                if_id_valid,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [31:0]         if_id_instr
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc4       = pc + FOUR;
    assign imem.addr = pc;

`ifdef IF_SKID_BUF_EN

    typedef enum logic {FETCH, BUFFERED} state_t;

    state_t            state;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;

    // Memory keeps delivering while frozen; the request stops only once the
    // skid slot is occupied.
    assign imem.req = (state == FETCH) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (br_taken) begin
            // Redirect wins over freeze; same-cycle ack and skid are dropped.
            pc          <= br_addr;
            state       <= FETCH;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ack) begin
                        pc <= pc4;
                        if (freeze) begin
                            skid_instr <= imem.rdata;
                            skid_pc4   <= pc4;
                            state      <= BUFFERED;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc4;
                            if_id_instr <= imem.rdata;
                        end
                    end else if (!freeze) begin
                        // Wait state: bubble, but keep pc/instr bits stable.
                        if_id_valid <= 1'b0;
                    end
                end
                BUFFERED: begin
                    if (!freeze) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= skid_pc4;
                        if_id_instr <= skid_instr;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`else

    // Without a skid slot a frozen cycle cannot accept a word, so no request.
    assign imem.req = ~rst & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (br_taken) begin
            pc          <= br_addr;
            if_id_valid <= 1'b0;
        end else if (!freeze) begin
            if (imem.ack) begin
                pc          <= pc4;
                if_id_valid <= 1'b1;
                if_id_pc    <= pc4;
                if_id_instr <= imem.rdata;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        rst, freeze, br_taken;
    logic [31:0] br_addr;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;

    if_fetch_stage_if #(.ADDR_W(32)) bus ();

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .imem       (bus),
        .if_id_valid(if_id_valid),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9617;
    endfunction

    // Reference model: the IF/ID register as a record, the skid buffer as a
    // queue of pending {instr, pc4} pairs (non-empty == parked).
    typedef struct packed {
        logic        v;
        logic [31:0] pc4;
        logic [31:0] ins;
    } ifid_t;

    ifid_t       m_ifid;
    ifid_t       held[$];
    logic [31:0] m_pc;

    function automatic logic model_req();
`ifdef IF_SKID_BUF_EN
        return !rst && held.size() == 0;
`else
        return !rst && !freeze;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic b,
                         input logic [31:0] ba, input logic a);
        rst = r; freeze = f; br_taken = b; br_addr = ba;
        bus.ack   = a;
        bus.rdata = a ? word_at(m_pc) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic check_model();
        chk("imem_req",    {31'd0, bus.req},     {31'd0, model_req()});
        chk("imem_addr",   bus.addr,             m_pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifid.v});
        chk("if_id_pc",    if_id_pc,             m_ifid.pc4);
        chk("if_id_instr", if_id_instr,          m_ifid.ins);
    endtask

    // Advance the model by the rules, then let the DUT take the same edge.
    task automatic tick();
        logic [31:0] w;
        w = word_at(m_pc);
        if (rst) begin
            m_pc = RPC; m_ifid = '0; held.delete();
        end else if (br_taken) begin
            m_pc = br_addr; m_ifid.v = 1'b0; held.delete();
        end else if (held.size() != 0) begin
            if (!freeze) m_ifid = held.pop_front();
        end else begin
`ifdef IF_SKID_BUF_EN
            if (bus.ack) begin
                if (freeze) held.push_back({1'b1, m_pc + 32'd4, w});
                else        m_ifid = {1'b1, m_pc + 32'd4, w};
                m_pc = m_pc + 32'd4;
            end else if (!freeze) begin
                m_ifid.v = 1'b0;
            end
`else
            if (!freeze) begin
                if (bus.ack) begin
                    m_ifid = {1'b1, m_pc + 32'd4, w};
                    m_pc   = m_pc + 32'd4;
                end else begin
                    m_ifid.v = 1'b0;
                end
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic a);
        apply(r, f, b, ba, a);
        check_model();
        tick();
    endtask

    typedef struct {
        logic        r, f, b, a;
        logic [31:0] ba;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Straight-line fetch, three wait states at 0x104, wrap-around branch.
        tbl[0]  = '{1,0,0,0, 32'h0,        0, 32'h100,        0, 32'h0,   32'h0};
        tbl[1]  = '{0,0,0,1, 32'h0,        1, 32'h100,        0, 32'h0,   32'h0};
        tbl[2]  = '{0,0,0,0, 32'h0,        1, 32'h104,        1, 32'h104, word_at(32'h100)};
        tbl[3]  = '{0,0,0,0, 32'h0,        1, 32'h104,        0, 32'h104, word_at(32'h100)};
        tbl[4]  = '{0,0,0,0, 32'h0,        1, 32'h104,        0, 32'h104, word_at(32'h100)};
        tbl[5]  = '{0,0,0,1, 32'h0,        1, 32'h104,        0, 32'h104, word_at(32'h100)};
        tbl[6]  = '{0,0,0,1, 32'h0,        1, 32'h108,        1, 32'h108, word_at(32'h104)};
        tbl[7]  = '{0,0,1,1, 32'hFFFFFFFC, 1, 32'h10C,        1, 32'h10C, word_at(32'h108)};
        tbl[8]  = '{0,0,0,1, 32'h0,        1, 32'hFFFFFFFC,   0, 32'h10C, word_at(32'h108)};
        tbl[9]  = '{0,0,0,1, 32'h0,        1, 32'h0,          1, 32'h0,   word_at(32'hFFFFFFFC)};
        tbl[10] = '{0,0,0,1, 32'h0,        1, 32'h4,          1, 32'h4,   word_at(32'h0)};

        m_pc = RPC; m_ifid = '0;
        apply(1, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].ba, tbl[i].a);
            chk($sformatf("tbl%0d.req", i),   {31'd0, bus.req},     {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d.addr", i),  bus.addr,             tbl[i].e_addr);
            chk($sformatf("tbl%0d.valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].e_v});
            chk($sformatf("tbl%0d.pc", i),    if_id_pc,             tbl[i].e_pc);
            chk($sformatf("tbl%0d.instr", i), if_id_instr,          tbl[i].e_ins);
            check_model();
            tick();
        end

        // Freeze for two cycles with an ack in the first frozen cycle.
        // PC is 0x8, IF/ID = {1, 0x8, word@0x4}.
        apply(0, 1, 0, 0, 1);
        chk("frz1.addr", bus.addr, 32'h8);
        check_model(); tick();
        apply(0, 1, 0, 0, 1);
`ifdef IF_SKID_BUF_EN
        chk("frz2.req",  {31'd0, bus.req}, 32'd0);
        chk("frz2.addr", bus.addr, 32'hC);
`else
        chk("frz2.req",  {31'd0, bus.req}, 32'd0);
        chk("frz2.addr", bus.addr, 32'h8);
`endif
        chk("frz2.pc",    if_id_pc,    32'h8);
        chk("frz2.instr", if_id_instr, word_at(32'h4));
        check_model(); tick();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 1);
        chk("frz_after.pc",    if_id_pc,    32'h10);
        chk("frz_after.instr", if_id_instr, word_at(32'hC));
        check_model(); tick();

        // Branch in the same cycle as freeze and ack, while parked.
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h40, 1);
        apply(0, 0, 0, 0, 0);
        chk("brp.valid", {31'd0, if_id_valid}, 32'd0);
        chk("brp.addr",  bus.addr, 32'h40);
        chk("brp.req",   {31'd0, bus.req}, 32'd1);
        check_model(); tick();
        step(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 1);
        chk("brp.instr", if_id_instr, word_at(32'h40));
        check_model(); tick();

        // Reset pulsed while parked under freeze, with an ack present.
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        apply(0, 0, 0, 0, 1);
        chk("rstw.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rstw.pc",    if_id_pc,    32'h0);
        chk("rstw.instr", if_id_instr, 32'h0);
        chk("rstw.addr",  bus.addr,    RPC);
        check_model(); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic r, f, b, a;
            logic [31:0] ba;
            r  = ($urandom_range(0, 63) == 0);
            b  = ($urandom_range(0, 11) == 0);
            f  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 2) != 0);
            ba = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) * 4);
            step(r, f, b, ba, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
